// File: rtl/mem_access_unit_if.sv
// CPU load/store, MMU translation and data-bus signals of the memory access unit.
// The master modport is the access unit itself; slave is the surrounding system.
interface mem_access_unit_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic            cpu_req;
    logic            cpu_we;
    logic [1:0]      cpu_len;
    logic            cpu_signed;
    logic [AW-1:0]   cpu_vaddr;
    logic [DW-1:0]   cpu_wdata;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_ready;
    logic [1:0]      cpu_exc;
    logic            tr_valid;
    logic [AW-1:0]   tr_vaddr;
    logic            tr_ack;
    logic [AW-1:0]   tr_paddr;
    logic            tr_fault;
    logic            bus_req;
    logic            bus_we;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [DW/8-1:0] bus_be;
    logic [DW-1:0]   bus_rdata;
    logic            bus_ready;

    modport master (
        input  cpu_req, cpu_we, cpu_len, cpu_signed, cpu_vaddr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_exc,
        output tr_valid, tr_vaddr,
        input  tr_ack, tr_paddr, tr_fault,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_rdata, bus_ready
    );

    modport slave (
        output cpu_req, cpu_we, cpu_len, cpu_signed, cpu_vaddr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_exc,
        input  tr_valid, tr_vaddr,
        output tr_ack, tr_paddr, tr_fault,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// CPU-side memory access sequencer: alignment check, MMU translation, big-endian bus
// access with sub-word stores done via byte enables or read-modify-write.
module mem_access_unit #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 32,
    parameter int unsigned HAS_BE = 0
) (
    input logic               clk,
    input logic               res,
    mem_access_unit_if.master io
);
    localparam int unsigned NB = DW / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [2:0] {StIdle, StXlate, StAccess, StWback, StDone} state_e;

    state_e         state;
    logic           we_q;
    logic           signed_q;
    logic [1:0]     len_q;
    logic [2:0]     off_q;
    logic [DW-1:0]  wdata_q;

    logic [2:0]     in_off;
    logic           misaligned;
    logic [3:0]     size_b;
    logic [7:0]     sh_lo;
    logic [7:0]     sh_hi;
    logic           sub_store;
    logic [DW-1:0]  placed;
    logic [DW-1:0]  lane_mask;
    logic [DW-1:0]  merged;
    logic [NB-1:0]  be_sub;
    logic [DW-1:0]  rd_shift;
    logic [DW-1:0]  ld_zext;
    logic signed [DW-1:0] ld_sext;
    logic [DW-1:0]  ld_val;

    always_comb begin
        in_off = 3'(io.cpu_vaddr[OW-1:0]);
        case (io.cpu_len)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = in_off[0];
            2'd2:    misaligned = |in_off[1:0];
            default: misaligned = (DW != 64) || (in_off != 3'd0);
        endcase
        size_b    = 4'd1 << len_q;
        sh_lo     = {2'b00, off_q, 3'b000};
        sh_hi     = 8'(DW) - {1'b0, size_b, 3'b000};
        sub_store = we_q && (32'(size_b) < NB);
        // Lane k sits at bits [DW-1-8k -: 8], so offsets shift right from the top.
        placed    = (wdata_q << sh_hi) >> sh_lo;
        lane_mask = ({DW{1'b1}} << sh_hi) >> sh_lo;
        merged    = (io.bus_rdata & ~lane_mask) | placed;
        be_sub    = ({NB{1'b1}} << (4'(NB) - size_b)) >> off_q;
        rd_shift  = io.bus_rdata << sh_lo;
        ld_sext   = $signed(rd_shift) >>> sh_hi;
        ld_zext   = rd_shift >> sh_hi;
        ld_val    = signed_q ? ld_sext : ld_zext;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state        <= StIdle;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            len_q        <= 2'd0;
            off_q        <= 3'd0;
            wdata_q      <= '0;
            io.cpu_rdata <= '0;
            io.cpu_ready <= 1'b0;
            io.cpu_exc   <= 2'd0;
            io.tr_valid  <= 1'b0;
            io.tr_vaddr  <= '0;
            io.bus_req   <= 1'b0;
            io.bus_we    <= 1'b0;
            io.bus_addr  <= '0;
            io.bus_wdata <= '0;
            io.bus_be    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (io.cpu_req) begin
                        we_q     <= io.cpu_we;
                        signed_q <= io.cpu_signed;
                        len_q    <= io.cpu_len;
                        off_q    <= in_off;
                        wdata_q  <= io.cpu_wdata;
                        if (misaligned) begin
                            state        <= StDone;
                            io.cpu_ready <= 1'b1;
                            io.cpu_exc   <= 2'd1;
                        end else begin
                            state       <= StXlate;
                            io.tr_valid <= 1'b1;
                            io.tr_vaddr <= io.cpu_vaddr;
                        end
                    end
                end
                StXlate: begin
                    if (io.tr_ack) begin
                        io.tr_valid <= 1'b0;
                        io.tr_vaddr <= '0;
                        if (io.tr_fault) begin
                            state        <= StDone;
                            io.cpu_ready <= 1'b1;
                            io.cpu_exc   <= 2'd2;
                        end else begin
                            state       <= StAccess;
                            io.bus_req  <= 1'b1;
                            io.bus_addr <= io.tr_paddr & ~AW'(NB - 1);
                            if (sub_store && HAS_BE != 0) begin
                                io.bus_we    <= 1'b1;
                                io.bus_be    <= be_sub;
                                io.bus_wdata <= placed;
                            end else if (sub_store) begin
                                // Read phase of the read-modify-write.
                                io.bus_we    <= 1'b0;
                                io.bus_be    <= '1;
                                io.bus_wdata <= '0;
                            end else begin
                                io.bus_we    <= we_q;
                                io.bus_be    <= '1;
                                io.bus_wdata <= we_q ? wdata_q : '0;
                            end
                        end
                    end
                end
                StAccess: begin
                    if (io.bus_ready) begin
                        io.bus_req <= 1'b0;
                        if (sub_store && HAS_BE == 0) begin
                            state        <= StWback;
                            io.bus_we    <= 1'b1;
                            io.bus_wdata <= merged;
                        end else begin
                            state        <= StDone;
                            io.cpu_ready <= 1'b1;
                            io.cpu_rdata <= we_q ? '0 : ld_val;
                            io.bus_we    <= 1'b0;
                            io.bus_addr  <= '0;
                            io.bus_wdata <= '0;
                            io.bus_be    <= '0;
                        end
                    end
                end
                StWback: begin
                    // First cycle idles the bus so the read and write are separate requests.
                    if (!io.bus_req) begin
                        io.bus_req <= 1'b1;
                    end else if (io.bus_ready) begin
                        state        <= StDone;
                        io.cpu_ready <= 1'b1;
                        io.bus_req   <= 1'b0;
                        io.bus_we    <= 1'b0;
                        io.bus_addr  <= '0;
                        io.bus_wdata <= '0;
                        io.bus_be    <= '0;
                    end
                end
                StDone: begin
                    state        <= StIdle;
                    io.cpu_ready <= 1'b0;
                    io.cpu_exc   <= 2'd0;
                    io.cpu_rdata <= '0;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: three instances (DW32 RMW, DW32 byte-enable, DW64 RMW)
// share stimulus; one responder/monitor serves whichever instance is selected.
module tb_mem_access_unit;
    logic clk;
    logic res;
    int   sel;
    logic req, we, sgn;
    logic [1:0]  len;
    logic [31:0] vaddr;
    logic [63:0] wdata;
    logic        tr_ack, tr_fault, bus_ready;
    logic [31:0] tr_paddr;
    logic [63:0] bus_rdata;

    int          tr_dly, bus_dly;
    logic [31:0] cfg_paddr;
    logic        cfg_fault;
    logic [63:0] mem;

    logic [2:0]  o_ready, o_trv, o_breq, o_bwe;
    logic [1:0]  o_exc [3];
    logic [63:0] o_rdata [3];
    logic [31:0] o_trva [3];
    logic [31:0] o_baddr [3];
    logic [63:0] o_bwd [3];
    logic [7:0]  o_bbe [3];

    int   tr_cnt, b_cnt, n_ph, n_rd, n_wr, n_unst, n_trv, n_rdy;
    logic [31:0] trva0, ph_addr;
    logic        ph_we;
    logic [63:0] ph_wd, wr_data, rd_val;
    logic [7:0]  ph_be, wr_be;
    logic [1:0]  rd_exc;
    time  t_req, t_rdy;
    int   checks, fails;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned GDW = (g == 2) ? 64 : 32;
        localparam int unsigned GBE = (g == 1) ? 1 : 0;
        mem_access_unit_if #(.DW(GDW), .AW(32)) ifc ();
        assign ifc.cpu_req    = req && (sel == g);
        assign ifc.cpu_we     = we;
        assign ifc.cpu_len    = len;
        assign ifc.cpu_signed = sgn;
        assign ifc.cpu_vaddr  = vaddr;
        assign ifc.cpu_wdata  = wdata[GDW-1:0];
        assign ifc.tr_ack     = tr_ack && (sel == g);
        assign ifc.tr_paddr   = tr_paddr;
        assign ifc.tr_fault   = tr_fault;
        assign ifc.bus_rdata  = bus_rdata[GDW-1:0];
        assign ifc.bus_ready  = bus_ready && (sel == g);
        assign o_ready[g] = ifc.cpu_ready;
        assign o_trv[g]   = ifc.tr_valid;
        assign o_breq[g]  = ifc.bus_req;
        assign o_bwe[g]   = ifc.bus_we;
        assign o_exc[g]   = ifc.cpu_exc;
        assign o_rdata[g] = 64'(ifc.cpu_rdata);
        assign o_trva[g]  = ifc.tr_vaddr;
        assign o_baddr[g] = ifc.bus_addr;
        assign o_bwd[g]   = 64'(ifc.bus_wdata);
        assign o_bbe[g]   = 8'(ifc.bus_be);
        mem_access_unit #(.DW(GDW), .AW(32), .HAS_BE(GBE)) u_dut (
            .clk(clk),
            .res(res),
            .io (ifc)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // MMU/bus responder and event monitor for the selected instance, active on negedges.
    initial begin
        int s;
        tr_ack = 0; tr_fault = 0; tr_paddr = 0; bus_ready = 0; bus_rdata = 0;
        tr_cnt = 0; b_cnt = 0; n_ph = 0; n_rd = 0; n_wr = 0; n_unst = 0; n_trv = 0; n_rdy = 0;
        trva0 = 0; ph_addr = 0; ph_we = 0; ph_wd = 0; ph_be = 0; wr_data = 0; wr_be = 0;
        rd_val = 0; rd_exc = 0; t_rdy = 0;
        forever begin
            @(negedge clk);
            s = sel;
            if (o_trv[s]) begin
                if (tr_cnt == 0) trva0 = o_trva[s];
                else if (o_trva[s] !== trva0) n_unst++;
                n_trv++;
                tr_ack   = (tr_cnt >= tr_dly);
                tr_paddr = cfg_paddr;
                tr_fault = cfg_fault;
                tr_cnt++;
            end else begin
                tr_ack = 0; tr_fault = 0; tr_cnt = 0;
            end
            bus_rdata = mem;
            if (o_breq[s]) begin
                if (b_cnt == 0) begin
                    n_ph++;
                    ph_addr = o_baddr[s]; ph_we = o_bwe[s]; ph_wd = o_bwd[s]; ph_be = o_bbe[s];
                end else if ({o_baddr[s], o_bwe[s], o_bwd[s], o_bbe[s]}
                             !== {ph_addr, ph_we, ph_wd, ph_be}) begin
                    n_unst++;
                end
                bus_ready = (b_cnt >= bus_dly);
                if (bus_ready) begin
                    if (ph_we) begin n_wr++; wr_data = ph_wd; wr_be = ph_be; end
                    else n_rd++;
                end
                b_cnt++;
            end else begin
                bus_ready = 0; b_cnt = 0;
            end
            if (o_ready[s]) begin
                n_rdy++; rd_val = o_rdata[s]; rd_exc = o_exc[s]; t_rdy = $time;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic run_req(input int s, input logic w, input logic [1:0] l, input logic sg,
                           input logic [31:0] va, input logic [63:0] wd, input int hold);
        int base, n;
        @(negedge clk);
        sel = s; we = w; len = l; sgn = sg; vaddr = va; wdata = wd;
        base = n_rdy; req = 1; t_req = $time;
        repeat (hold) @(negedge clk);
        req = 0;
        n = 0;
        while (n_rdy == base && n < 60) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        res = 1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({o_ready[g], o_trv[g], o_breq[g], o_bwe[g], o_exc[g], o_rdata[g], o_trva[g],
                 o_baddr[g], o_bwd[g], o_bbe[g]} !== '0) begin
                fails++;
                $display("FAIL reset_outputs dut%0d: got ready=%b trv=%b breq=%b rdata=%h baddr=%h, required all 0",
                         g, o_ready[g], o_trv[g], o_breq[g], o_rdata[g], o_baddr[g]);
            end
        end
        res = 0;
    endtask

    task automatic test_word_load();
        int r0, w0;
        cfg_paddr = 32'h8000; mem = 64'hDEADBEEF; r0 = n_rdy; w0 = n_wr;
        run_req(0, 0, 2'd2, 0, 32'h1000, 0, 1);
        checks++; if (n_rdy - r0 !== 1) begin fails++; $display("FAIL word_load_pulses got=%0d exp=1", n_rdy - r0); end
        checks++; if (rd_val !== 64'hDEADBEEF) begin fails++; $display("FAIL word_load_rdata got=%h exp=deadbeef", rd_val); end
        checks++; if (rd_exc !== 2'd0) begin fails++; $display("FAIL word_load_exc got=%0d exp=0", rd_exc); end
        checks++; if (ph_addr !== 32'h8000) begin fails++; $display("FAIL word_load_addr got=%h exp=8000", ph_addr); end
        checks++; if (ph_be !== 8'h0F) begin fails++; $display("FAIL word_load_be got=%b exp=1111", ph_be); end
        checks++; if (n_wr - w0 !== 0 || ph_we !== 1'b0) begin fails++; $display("FAIL word_load_nowrite writes=%0d we=%b exp 0", n_wr - w0, ph_we); end
        checks++; if (t_rdy - t_req !== 64'd30) begin fails++; $display("FAIL word_load_latency got=%0d exp=30", t_rdy - t_req); end
    endtask

    task automatic test_byte_load();
        cfg_paddr = 32'h8001; mem = 64'h12803456;
        run_req(0, 0, 2'd0, 1, 32'h1001, 0, 1);
        checks++; if (rd_val !== 64'hFFFFFF80) begin fails++; $display("FAIL byte_load_signed got=%h exp=ffffff80", rd_val); end
        checks++; if (ph_addr !== 32'h8000) begin fails++; $display("FAIL byte_load_addr got=%h exp=8000", ph_addr); end
        run_req(0, 0, 2'd0, 0, 32'h1001, 0, 1);
        checks++; if (rd_val !== 64'h80) begin fails++; $display("FAIL byte_load_unsigned got=%h exp=80", rd_val); end
    endtask

    task automatic test_rmw_store();
        int r0, rd0, w0, p0;
        cfg_paddr = 32'h8002; mem = 64'h11223344;
        r0 = n_rdy; rd0 = n_rd; w0 = n_wr; p0 = n_ph;
        run_req(0, 1, 2'd0, 0, 32'h1002, 64'hAB, 1);
        checks++; if (n_rd - rd0 !== 1 || n_wr - w0 !== 1) begin fails++; $display("FAIL rmw_counts reads=%0d writes=%0d exp 1/1", n_rd - rd0, n_wr - w0); end
        checks++; if (n_ph - p0 !== 2) begin fails++; $display("FAIL rmw_gap phases=%0d exp=2", n_ph - p0); end
        checks++; if (wr_data !== 64'h1122AB44) begin fails++; $display("FAIL rmw_wdata got=%h exp=1122ab44", wr_data); end
        checks++; if (wr_be !== 8'h0F || ph_addr !== 32'h8000) begin fails++; $display("FAIL rmw_be_addr be=%b addr=%h exp 1111/8000", wr_be, ph_addr); end
        checks++; if (n_rdy - r0 !== 1) begin fails++; $display("FAIL rmw_pulses got=%0d exp=1", n_rdy - r0); end
        checks++; if (rd_val !== 64'd0 || rd_exc !== 2'd0) begin fails++; $display("FAIL rmw_result rdata=%h exc=%0d exp 0/0", rd_val, rd_exc); end
    endtask

    task automatic test_be_store();
        int rd0, w0, p0;
        cfg_paddr = 32'h9002; mem = 64'h55555555;
        rd0 = n_rd; w0 = n_wr; p0 = n_ph;
        run_req(1, 1, 2'd1, 0, 32'h2002, 64'hBEEF, 1);
        checks++; if (n_rd - rd0 !== 0 || n_wr - w0 !== 1 || n_ph - p0 !== 1) begin fails++; $display("FAIL be_store_single reads=%0d writes=%0d phases=%0d exp 0/1/1", n_rd - rd0, n_wr - w0, n_ph - p0); end
        checks++; if (wr_be !== 8'h03) begin fails++; $display("FAIL be_store_be got=%b exp=0011", wr_be); end
        checks++; if (wr_data !== 64'h0000BEEF) begin fails++; $display("FAIL be_store_wdata got=%h exp=0000beef", wr_data); end
        checks++; if (ph_addr !== 32'h9000) begin fails++; $display("FAIL be_store_addr got=%h exp=9000", ph_addr); end
    endtask

    task automatic test_exceptions();
        int t0, p0;
        cfg_paddr = 32'h8000; mem = 64'h0;
        t0 = n_trv; p0 = n_ph;
        run_req(0, 0, 2'd1, 0, 32'h1003, 0, 1);
        checks++; if (rd_exc !== 2'd1) begin fails++; $display("FAIL misaligned_half_exc got=%0d exp=1", rd_exc); end
        checks++; if (n_trv - t0 !== 0 || n_ph - p0 !== 0) begin fails++; $display("FAIL misaligned_quiet tr_cycles=%0d bus_phases=%0d exp 0/0", n_trv - t0, n_ph - p0); end
        checks++; if (t_rdy - t_req !== 64'd10) begin fails++; $display("FAIL misaligned_latency got=%0d exp=10", t_rdy - t_req); end
        t0 = n_trv;
        run_req(0, 0, 2'd3, 0, 32'h1000, 0, 1);
        checks++; if (rd_exc !== 2'd1 || n_trv - t0 !== 0) begin fails++; $display("FAIL dword_on_dw32 exc=%0d tr_cycles=%0d exp 1/0", rd_exc, n_trv - t0); end
        run_req(2, 0, 2'd3, 0, 32'h3004, 0, 1);
        checks++; if (rd_exc !== 2'd1) begin fails++; $display("FAIL dw64_misaligned_dword exc=%0d exp=1", rd_exc); end
        cfg_fault = 1; p0 = n_ph;
        run_req(0, 0, 2'd2, 0, 32'h1000, 0, 1);
        cfg_fault = 0;
        checks++; if (rd_exc !== 2'd2 || rd_val !== 64'd0) begin fails++; $display("FAIL xlate_fault exc=%0d rdata=%h exp 2/0", rd_exc, rd_val); end
        checks++; if (n_ph - p0 !== 0) begin fails++; $display("FAIL xlate_fault_nobus phases=%0d exp=0", n_ph - p0); end
    endtask

    task automatic test_dword_delayed();
        int u0, t0;
        cfg_paddr = 32'hA000; mem = 64'h0123456789ABCDEF; tr_dly = 5; bus_dly = 5;
        u0 = n_unst; t0 = n_trv;
        run_req(2, 0, 2'd3, 0, 32'h3000, 0, 1);
        tr_dly = 0; bus_dly = 0;
        checks++; if (rd_val !== 64'h0123456789ABCDEF || rd_exc !== 2'd0) begin fails++; $display("FAIL dword_rdata got=%h exc=%0d exp 0123456789abcdef/0", rd_val, rd_exc); end
        checks++; if (n_unst - u0 !== 0) begin fails++; $display("FAIL dword_stable unstable_cycles=%0d exp=0", n_unst - u0); end
        checks++; if (n_trv - t0 !== 6) begin fails++; $display("FAIL dword_tr_cycles got=%0d exp=6", n_trv - t0); end
        checks++; if (ph_be !== 8'hFF || ph_addr !== 32'hA000) begin fails++; $display("FAIL dword_be_addr be=%h addr=%h exp ff/a000", ph_be, ph_addr); end
        checks++; if (t_rdy - t_req !== 64'd130) begin fails++; $display("FAIL dword_latency got=%0d exp=130", t_rdy - t_req); end
        run_req(2, 0, 2'd1, 0, 32'h3006, 0, 1);
        checks++; if (rd_val !== 64'hCDEF) begin fails++; $display("FAIL dw64_half_off6 got=%h exp=cdef", rd_val); end
        run_req(2, 0, 2'd0, 1, 32'h3004, 0, 1);
        checks++; if (rd_val !== 64'hFFFFFFFFFFFFFF89) begin fails++; $display("FAIL dw64_sbyte_off4 got=%h exp=ffffffffffffff89", rd_val); end
    endtask

    task automatic test_reset_mid_wback();
        int r0, n;
        logic reached;
        cfg_paddr = 32'h8002; mem = 64'h11223344; bus_dly = 4;
        @(negedge clk);
        sel = 0; we = 1; len = 0; sgn = 0; vaddr = 32'h1002; wdata = 64'hAB; req = 1;
        r0 = n_rdy;
        @(negedge clk);
        req = 0;
        reached = 0; n = 0;
        while (!reached && n < 40) begin
            @(negedge clk); n++;
            if (o_breq[0] && o_bwe[0]) reached = 1;
        end
        checks++; if (reached !== 1'b1) begin fails++; $display("FAIL reset_wback_reached got=%b exp=1", reached); end
        #2 res = 1;
        #1;
        checks++;
        if ({o_breq[0], o_bwe[0], o_trv[0], o_ready[0], o_bwd[0], o_bbe[0], o_baddr[0]} !== '0) begin
            fails++;
            $display("FAIL reset_async breq=%b bwe=%b wdata=%h be=%b addr=%h exp all 0",
                     o_breq[0], o_bwe[0], o_bwd[0], o_bbe[0], o_baddr[0]);
        end
        @(negedge clk);
        res = 0; bus_dly = 0;
        repeat (4) @(negedge clk);
        checks++; if (n_rdy - r0 !== 0) begin fails++; $display("FAIL reset_no_ready pulses=%0d exp=0", n_rdy - r0); end
        cfg_paddr = 32'h8000; mem = 64'h0BADF00D;
        run_req(0, 0, 2'd2, 0, 32'h1000, 0, 1);
        checks++; if (rd_val !== 64'h0BADF00D) begin fails++; $display("FAIL reset_then_load got=%h exp=0badf00d", rd_val); end
    endtask

    task automatic test_back_to_back();
        int r0;
        cfg_paddr = 32'h8004; mem = 64'hCAFEF00D; r0 = n_rdy;
        run_req(0, 0, 2'd2, 0, 32'h1004, 0, 8);
        checks++; if (n_rdy - r0 !== 2) begin fails++; $display("FAIL back_to_back_pulses got=%0d exp=2", n_rdy - r0); end
        checks++; if (rd_val !== 64'hCAFEF00D) begin fails++; $display("FAIL back_to_back_rdata got=%h exp=cafef00d", rd_val); end
    endtask

    initial begin
        res = 1; sel = 0; req = 0; we = 0; len = 0; sgn = 0; vaddr = 0; wdata = 0;
        tr_dly = 0; bus_dly = 0; cfg_paddr = 0; cfg_fault = 0; mem = 0;
        t_req = 0; checks = 0; fails = 0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_rmw_store();
        test_be_store();
        test_exceptions();
        test_dword_delayed();
        test_reset_mid_wback();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
